// File: rtl/core_pipe_pkg.sv
// Shared definitions for the five-stage core pipeline registers:
// per-stage payload widths, IF/ID field offsets and the occupancy type.
package core_pipe_pkg;

    // IF/ID payload: {next address, PC, instruction word}
    localparam int unsigned IFID_INSTR_LSB = 0;
    localparam int unsigned IFID_INSTR_W   = 32;
    localparam int unsigned IFID_OPC_LSB   = 0;
    localparam int unsigned IFID_OPC_W     = 7;
    localparam int unsigned IFID_PC_LSB    = 32;
    localparam int unsigned IFID_PC_W      = 25;
    localparam int unsigned IFID_NPC_LSB   = 57;
    localparam int unsigned IFID_NPC_W     = 25;

    localparam int unsigned IFID_W  = 82;
    localparam int unsigned IDEX_W  = 120;
    localparam int unsigned EXMEM_W = 80;
    localparam int unsigned MEMWB_W = 72;

    typedef logic [1:0] occ_t;

    function automatic occ_t occ_count(input logic main_v, input logic skid_v);
        return occ_t'({1'b0, main_v}) + occ_t'({1'b0, skid_v});
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline storage slot: W-bit payload plus valid flag.
// clear (flush) beats load, load beats drop; drop keeps the payload.
module pipe_entry #(
    parameter int unsigned     W       = 1,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         drop,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= RST_VAL;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= RST_VAL;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, stall,
// flush, optional 2-entry skid buffer and sticky interrupt tagging.
module pipe_stage_reg
    import core_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W  = IFID_W,
    parameter int unsigned       SKID    = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              int_in,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_int,
    output occ_t              occupancy
);

    localparam int unsigned     EW        = DATA_W + 1;
    localparam logic [EW-1:0]   ENTRY_RST = {1'b0, RST_VAL};

    logic          acc;
    logic          pop;
    logic          int_pend;
    logic          int_tag;
    logic          main_v;
    logic          main_load;
    logic          main_drop;
    logic [EW-1:0] main_d;
    logic [EW-1:0] main_q;
    logic          skid_v;
    logic [EW-1:0] skid_q;

    assign acc     = in_valid & in_ready;
    assign pop     = main_v & out_ready & ~stall;
    assign int_tag = int_pend | int_in;

    assign out_valid = main_v;
    assign out_int   = main_q[EW-1];
    assign out_data  = main_q[DATA_W-1:0];
    assign occupancy = occ_count(main_v, skid_v);

    // The interrupt tag is attached when the word is accepted, so a word
    // parked in skid keeps its tag when it later moves into main.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            int_pend <= 1'b0;
        else if (flush)
            int_pend <= int_tag;
        else if (acc)
            int_pend <= 1'b0;
        else
            int_pend <= int_tag;
    end

    pipe_entry #(.W(EW), .RST_VAL(ENTRY_RST)) u_main (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .load  (main_load),
        .drop  (main_drop),
        .d     (main_d),
        .valid (main_v),
        .q     (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic skid_load;
            logic skid_drop;

            // in_ready depends only on registered state; acc therefore never
            // coincides with skid_v, so a skid->main move and an acc are exclusive.
            assign in_ready  = ~skid_v;
            assign main_load = (pop & skid_v) | (acc & (~main_v | pop));
            assign main_drop = pop & ~main_load;
            assign main_d    = skid_v ? skid_q : {int_tag, in_data};
            assign skid_load = acc & main_v & ~pop;
            assign skid_drop = pop & skid_v;

            pipe_entry #(.W(EW), .RST_VAL(ENTRY_RST)) u_skid (
                .clk   (clk),
                .rst   (rst),
                .clear (flush),
                .load  (skid_load),
                .drop  (skid_drop),
                .d     ({int_tag, in_data}),
                .valid (skid_v),
                .q     (skid_q)
            );
        end else begin : g_noskid
            assign in_ready  = ~main_v | pop;
            assign main_load = acc;
            assign main_drop = pop & ~acc;
            assign main_d    = {int_tag, in_data};
            assign skid_v    = 1'b0;
            assign skid_q    = ENTRY_RST;
        end
    endgenerate

    a_skid_implies_main: assert property (
        @(posedge clk) disable iff (rst) skid_v |-> main_v
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share
// all inputs and are checked against hand-computed expectations.
module tb_pipe_stage_reg;
    import core_pipe_pkg::*;

    localparam int unsigned    DW = 82;
    localparam logic [DW-1:0]  RV = 82'h3C;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          int_in;
    logic          stall;
    logic          flush;
    logic          out_ready;

    logic          a_in_ready, a_out_valid, a_out_int;
    logic [DW-1:0] a_out_data;
    occ_t          a_occ;
    logic          b_in_ready, b_out_valid, b_out_int;
    logic [DW-1:0] b_out_data;
    occ_t          b_occ;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    pipe_stage_reg #(.DATA_W(DW), .SKID(1), .RST_VAL(RV)) dut_skid (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .int_in(int_in), .stall(stall), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_int(a_out_int), .occupancy(a_occ)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(0), .RST_VAL(RV)) dut_flop (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .int_in(int_in), .stall(stall), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_int(b_out_int), .occupancy(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid  = 1'b0;
        in_data   = '0;
        int_in    = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        check("rst_a_valid", a_out_valid, 1'b0);
        check("rst_a_occ",   a_occ,       2'd0);
        check("rst_a_data",  a_out_data,  RV);
        check("rst_a_int",   a_out_int,   1'b0);
        check("rst_a_ready", a_in_ready,  1'b1);
        check("rst_b_valid", b_out_valid, 1'b0);
        check("rst_b_data",  b_out_data,  RV);
        check("rst_b_ready", b_in_ready,  1'b1);
        rst = 1'b0;
        #1;
        check("post_rst_a_ready", a_in_ready, 1'b1);
        check("post_rst_b_ready", b_in_ready, 1'b1);

        // 1: latency and back-to-back throughput
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = DW'(12'h155 + i);
            tick();
            check("t1_a_valid", a_out_valid, 1'b1);
            check("t1_a_data",  a_out_data,  DW'(12'h155 + i));
            check("t1_a_occ",   a_occ,       2'd1);
            check("t1_b_valid", b_out_valid, 1'b1);
            check("t1_b_data",  b_out_data,  DW'(12'h155 + i));
        end
        in_valid = 1'b0;
        tick();
        check("t1_a_drain", a_out_valid, 1'b0);
        check("t1_b_drain", b_out_valid, 1'b0);
        check("t1_a_occ0",  a_occ,       2'd0);

        // 2: skid fill and ordered drain (SKID=1 only)
        do_reset();
        in_valid = 1'b1; in_data = 82'hA;
        tick();
        check("t2_occ1", a_occ, 2'd1);
        in_data = 82'hB;
        tick();
        check("t2_occ2",   a_occ,      2'd2);
        check("t2_ready0", a_in_ready, 1'b0);
        check("t2_headA",  a_out_data, 82'hA);
        in_data = 82'hC;
        tick();
        check("t2_hold_occ",  a_occ,      2'd2);
        check("t2_hold_headA", a_out_data, 82'hA);
        out_ready = 1'b1;
        tick();
        check("t2_headB",  a_out_data, 82'hB);
        check("t2_occ_b",  a_occ,      2'd1);
        check("t2_ready1", a_in_ready, 1'b1);
        tick();
        check("t2_headC",  a_out_data, 82'hC);
        check("t2_occ_c",  a_occ,      2'd1);
        in_valid = 1'b0;
        tick();
        check("t2_empty",  a_out_valid, 1'b0);

        // 3: stall freezes the output; upstream accepted while in_ready=1
        do_reset();
        in_valid = 1'b1; in_data = 82'h2A;
        tick();
        stall = 1'b1; out_ready = 1'b1; in_data = 82'h2B;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_a_data",  a_out_data,  82'h2A);
            check("t3_a_valid", a_out_valid, 1'b1);
            check("t3_a_occ",   a_occ,       2'd2);
            check("t3_a_ready", a_in_ready,  1'b0);
            check("t3_b_data",  b_out_data,  82'h2A);
            check("t3_b_ready", b_in_ready,  1'b0);
        end
        stall = 1'b0;
        #1;
        check("t3_b_ready_unstall", b_in_ready, 1'b1);
        tick();
        check("t3_a_next", a_out_data, 82'h2B);
        check("t3_a_occ1", a_occ,      2'd1);
        check("t3_b_next", b_out_data, 82'h2B);
        in_valid = 1'b0;
        tick();
        check("t3_a_popped", a_out_valid, 1'b0);
        check("t3_b_popped", b_out_valid, 1'b0);

        // 4: flush (with stall) beats acc with the stage full
        do_reset();
        in_valid = 1'b1; in_data = 82'h11;
        tick();
        in_data = 82'h22;
        tick();
        check("t4_a_full", a_occ, 2'd2);
        check("t4_b_full", b_occ, 2'd1);
        flush = 1'b1; stall = 1'b1; in_data = 82'h33;
        tick();
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        check("t4_a_valid", a_out_valid, 1'b0);
        check("t4_a_occ",   a_occ,       2'd0);
        check("t4_a_data",  a_out_data,  RV);
        check("t4_a_ready", a_in_ready,  1'b1);
        check("t4_b_valid", b_out_valid, 1'b0);
        check("t4_b_occ",   b_occ,       2'd0);
        check("t4_b_data",  b_out_data,  RV);
        check("t4_b_ready", b_in_ready,  1'b1);

        // 5: sticky interrupt capture
        do_reset();
        out_ready = 1'b1;
        int_in = 1'b1;
        tick();
        int_in = 1'b0;
        tick();
        tick();
        in_valid = 1'b1; in_data = 82'hD;
        tick();
        check("t5_a_D_int", a_out_int, 1'b1);
        check("t5_b_D_int", b_out_int, 1'b1);
        check("t5_a_D",     a_out_data, 82'hD);
        in_data = 82'hE;
        tick();
        check("t5_a_E_int", a_out_int, 1'b0);
        check("t5_b_E_int", b_out_int, 1'b0);
        in_valid = 1'b0; flush = 1'b1; int_in = 1'b1;
        tick();
        flush = 1'b0; int_in = 1'b0;
        in_valid = 1'b1; in_data = 82'hF;
        tick();
        check("t5_a_F_int", a_out_int, 1'b1);
        check("t5_b_F_int", b_out_int, 1'b1);
        in_data = 82'h6; int_in = 1'b1;
        tick();
        int_in = 1'b0;
        check("t5_a_same_edge", a_out_int, 1'b1);
        in_data = 82'h7;
        tick();
        check("t5_a_no_pend", a_out_int, 1'b0);
        check("t5_b_no_pend", b_out_int, 1'b0);
        in_valid = 1'b0;
        tick();

        // 6: asynchronous reset mid-cycle with the stage full
        do_reset();
        in_valid = 1'b1; in_data = 82'h44;
        tick();
        in_data = 82'h55;
        tick();
        in_valid = 1'b0;
        check("t6_full", a_occ, 2'd2);
        #2;
        rst = 1'b1;
        #1;
        check("t6_a_valid", a_out_valid, 1'b0);
        check("t6_a_occ",   a_occ,       2'd0);
        check("t6_a_data",  a_out_data,  RV);
        check("t6_b_valid", b_out_valid, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_stays_empty", a_occ, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
